// File: rtl/ldst_issue.sv
// rtl/ldst_issue.sv - load/store request initiator between EX and data memory
// One transaction in flight; loads return data on the WB port, faults raise a sticky err.
module ldst_issue #(
  parameter int D_SIZE        = 32,
  parameter int ADDR_LINE_MEM = 14,
  parameter int ADDR_LINE_REG = 5,
  parameter int TIMEOUT       = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ex_valid,
  output logic                     ex_ready,
  input  logic                     ex_is_load,
  input  logic                     ex_is_store,
  input  logic [ADDR_LINE_MEM-1:0] ex_addr,
  input  logic [D_SIZE-1:0]        ex_wdata,
  input  logic [ADDR_LINE_REG-1:0] ex_rd,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDR_LINE_MEM-1:0] mem_addr,
  output logic [D_SIZE-1:0]        mem_wdata,
  input  logic                     mem_gnt,
  input  logic                     mem_rvalid,
  input  logic [D_SIZE-1:0]        mem_rdata,
  output logic                     wb_valid,
  output logic [ADDR_LINE_REG-1:0] wb_rd,
  output logic [D_SIZE-1:0]        wb_data,
  output logic                     err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RD} state_t;

  state_t                     state_q, state_d;
  logic [CW-1:0]              cnt_q, cnt_d, cnt_inc;
  logic [ADDR_LINE_REG-1:0]   rd_q, rd_d;
  logic                       mem_req_q, mem_req_d;
  logic                       mem_we_q, mem_we_d;
  logic [ADDR_LINE_MEM-1:0]   mem_addr_q, mem_addr_d;
  logic [D_SIZE-1:0]          mem_wdata_q, mem_wdata_d;
  logic                       wb_valid_q, wb_valid_d;
  logic [ADDR_LINE_REG-1:0]   wb_rd_q, wb_rd_d;
  logic [D_SIZE-1:0]          wb_data_q, wb_data_d;
  logic                       err_q, err_d;
  logic                       timeout_hit;

  assign cnt_inc     = cnt_q + 1'b1;
  assign timeout_hit = (cnt_inc == CW'(TIMEOUT));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wb_valid_d  = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (mem_rvalid) err_d = 1'b1;
        if (ex_valid && (ex_is_load || ex_is_store)) begin
          // The mem_* output flops double as the holding registers for the request.
          mem_addr_d  = ex_addr;
          mem_wdata_d = ex_wdata;
          mem_we_d    = ex_is_store;
          rd_d        = ex_rd;
          mem_req_d   = 1'b1;
          cnt_d       = '0;
          state_d     = REQ;
          if (ex_is_load && ex_is_store) err_d = 1'b1;
        end
      end
      REQ: begin
        if (mem_rvalid) err_d = 1'b1;
        // A grant in the final allowed cycle still wins over the timeout.
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          cnt_d     = '0;
          state_d   = mem_we_q ? IDLE : WAIT_RD;
        end else if (timeout_hit) begin
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      WAIT_RD: begin
        if (mem_rvalid) begin
          wb_data_d  = mem_rdata;
          wb_rd_d    = rd_q;
          wb_valid_d = (rd_q != '0);
          cnt_d      = '0;
          state_d    = IDLE;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rd_q        <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      err_q       <= err_d;
    end
  end

  assign ex_ready  = (state_q == IDLE);
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign wb_valid  = wb_valid_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ldst_issue.sv
// tb/tb_ldst_issue.sv - directed bench for ldst_issue
// Per-cycle vector table for the main traffic, hand sequences for timeouts, stray rvalid and reset.
module tb_ldst_issue;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ex_valid = 1'b0, ex_is_load = 1'b0, ex_is_store = 1'b0;
  logic [13:0] ex_addr = '0;
  logic [31:0] ex_wdata = '0;
  logic [4:0]  ex_rd = '0;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        ex_ready, mem_req, mem_we, wb_valid, err;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata, wb_data;
  logic [4:0]  wb_rd;

  int checks = 0;
  int errors = 0;

  ldst_issue #(.D_SIZE(32), .ADDR_LINE_MEM(14), .ADDR_LINE_REG(5), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .err(err)
  );

  always #5 clk = ~clk;

  // {ex_ready, mem_req, mem_we, mem_addr, mem_wdata, wb_valid, wb_rd, wb_data, err}
  typedef logic [87:0] obs_t;

  typedef struct {
    logic        v, ld, st;
    logic [13:0] a;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic        g, rv;
    logic [31:0] rdt;
    obs_t        exp;
  } vec_t;

  function automatic vec_t mk(input logic v, ld, st, input logic [13:0] a, input logic [31:0] wd,
                              input logic [4:0] rd, input logic g, rv, input logic [31:0] rdt,
                              input logic e_rdy, e_req, e_we, input logic [13:0] e_a,
                              input logic [31:0] e_wd, input logic e_wbv, input logic [4:0] e_wbrd,
                              input logic [31:0] e_wbd, input logic e_err);
    vec_t r;
    r.v = v; r.ld = ld; r.st = st; r.a = a; r.wd = wd; r.rd = rd;
    r.g = g; r.rv = rv; r.rdt = rdt;
    r.exp = {e_rdy, e_req, e_we, e_a, e_wd, e_wbv, e_wbrd, e_wbd, e_err};
    return r;
  endfunction

  function automatic obs_t observe();
    return {ex_ready, mem_req, mem_we, mem_addr, mem_wdata, wb_valid, wb_rd, wb_data, err};
  endfunction

  task automatic check(input string name, input logic [87:0] act, input logic [87:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, ld, st, input logic [13:0] a, input logic [31:0] wd,
                       input logic [4:0] rd, input logic g, rv, input logic [31:0] rdt);
    @(negedge clk);
    ex_valid = v; ex_is_load = ld; ex_is_store = st; ex_addr = a; ex_wdata = wd; ex_rd = rd;
    mem_gnt = g; mem_rvalid = rv; mem_rdata = rdt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    ex_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  vec_t vecs[16];
  int   n;
  logic saw_wb;

  initial begin
    vecs[0]  = mk(1,0,1,14'h0400,32'hDEADBEEF,0,1,0,0, 0,1,1,14'h0400,32'hDEADBEEF,0,0,0,0);
    vecs[1]  = mk(0,0,0,0,0,0,1,0,0,                   1,0,1,14'h0400,32'hDEADBEEF,0,0,0,0);
    vecs[2]  = mk(1,1,0,14'h0400,0,7,0,0,0,            0,1,0,14'h0400,0,0,0,0,0);
    vecs[3]  = mk(0,0,0,0,0,0,0,0,0,                   0,1,0,14'h0400,0,0,0,0,0);
    vecs[4]  = mk(0,0,0,0,0,0,0,0,0,                   0,1,0,14'h0400,0,0,0,0,0);
    vecs[5]  = mk(0,0,0,0,0,0,0,0,0,                   0,1,0,14'h0400,0,0,0,0,0);
    vecs[6]  = mk(0,0,0,0,0,0,1,0,0,                   0,0,0,14'h0400,0,0,0,0,0);
    vecs[7]  = mk(0,0,0,0,0,0,0,1,32'hDEADBEEF,        1,0,0,14'h0400,0,1,7,32'hDEADBEEF,0);
    vecs[8]  = mk(0,0,0,0,0,0,0,0,0,                   1,0,0,14'h0400,0,0,7,32'hDEADBEEF,0);
    vecs[9]  = mk(1,1,0,14'h0010,0,0,1,0,0,            0,1,0,14'h0010,0,0,7,32'hDEADBEEF,0);
    vecs[10] = mk(0,0,0,0,0,0,1,0,0,                   0,0,0,14'h0010,0,0,7,32'hDEADBEEF,0);
    vecs[11] = mk(0,0,0,0,0,0,0,1,32'h12345678,        1,0,0,14'h0010,0,0,0,32'h12345678,0);
    vecs[12] = mk(1,0,0,14'h3FFF,32'h11111111,4,0,0,0, 1,0,0,14'h0010,0,0,0,32'h12345678,0);
    vecs[13] = mk(1,1,1,14'h0020,32'hCAFEF00D,3,1,0,0, 0,1,1,14'h0020,32'hCAFEF00D,0,0,32'h12345678,1);
    vecs[14] = mk(0,0,0,0,0,0,1,0,0,                   1,0,1,14'h0020,32'hCAFEF00D,0,0,32'h12345678,1);
    vecs[15] = mk(0,0,0,0,0,0,0,0,0,                   1,0,1,14'h0020,32'hCAFEF00D,0,0,32'h12345678,1);

    #12;
    check("reset_values", observe(), {1'b1, 1'b0, 1'b0, 14'h0, 32'h0, 1'b0, 5'h0, 32'h0, 1'b0});
    do_reset();

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].v, vecs[i].ld, vecs[i].st, vecs[i].a, vecs[i].wd, vecs[i].rd,
            vecs[i].g, vecs[i].rv, vecs[i].rdt);
      tick();
      check($sformatf("vec%0d", i), observe(), vecs[i].exp);
    end

    // Grant never arrives: request held TIMEOUT cycles then aborted.
    do_reset();
    drive(1,1,0,14'h0005,0,1,0,0,0);
    tick();
    ex_valid = 1'b0;
    n = 0; saw_wb = 1'b0;
    while (mem_req && n < 20) begin
      n++;
      tick();
      if (wb_valid) saw_wb = 1'b1;
    end
    check("gnt_timeout_req_cycles", 88'(n), 88'd4);
    check("gnt_timeout_flags", {85'd0, err, ex_ready, saw_wb}, {85'd0, 1'b1, 1'b1, 1'b0});

    // Read data never returns: WAIT_RD aborts after TIMEOUT cycles.
    do_reset();
    drive(1,1,0,14'h0006,0,2,1,0,0);
    tick();
    ex_valid = 1'b0;
    tick();
    mem_gnt = 1'b0;
    n = 0; saw_wb = 1'b0;
    while (!ex_ready && n < 20) begin
      n++;
      tick();
      if (wb_valid) saw_wb = 1'b1;
    end
    check("rvalid_timeout_wait_cycles", 88'(n), 88'd4);
    check("rvalid_timeout_flags", {85'd0, err, mem_req, saw_wb}, {85'd0, 1'b1, 1'b0, 1'b0});

    // Stray rvalid while idle.
    do_reset();
    drive(0,0,0,0,0,0,0,1,32'h55555555);
    tick();
    mem_rvalid = 1'b0;
    tick();
    check("stray_rvalid", {86'd0, err, wb_valid}, {86'd0, 1'b1, 1'b0});

    // Reset asserted while waiting for read data, then a clean load.
    do_reset();
    drive(1,1,0,14'h0123,32'h0,5,1,0,0);
    tick();
    ex_valid = 1'b0;
    tick();
    mem_gnt = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("async_reset_mid_load", observe(), {1'b1, 1'b0, 1'b0, 14'h0, 32'h0, 1'b0, 5'h0, 32'h0, 1'b0});
    @(negedge clk);
    reset = 1'b1;
    drive(1,1,0,14'h0400,0,9,1,0,0);
    tick();
    ex_valid = 1'b0;
    tick();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hA5A5A5A5;
    tick();
    mem_rvalid = 1'b0;
    check("load_after_reset", observe(), {1'b1, 1'b0, 1'b0, 14'h0400, 32'h0, 1'b1, 5'd9, 32'hA5A5A5A5, 1'b0});
    tick();
    check("wb_pulse_one_cycle", {87'd0, wb_valid}, 88'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
